// File: rtl/ram_pkg.sv
// Shared types and constants for the single-port RAM with clear engine.
package ram_pkg;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } ram_state_t;

  localparam bit RAM_READ_FIRST  = 1'b0;
  localparam bit RAM_WRITE_FIRST = 1'b1;

  // True when the clear counter has reached the last location.
  function automatic logic sweep_last(input logic [31:0] cnt, input int addr_w);
    return cnt == (32'(1) << addr_w) - 32'd1;
  endfunction

endpackage

// File: rtl/ram_sp_clr_if.sv
// User-side bus of ram_sp_clr: access controls, read data with valid strobe, busy and FSM state.
interface ram_sp_clr_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
);
  import ram_pkg::*;

  // Handshake: an access (we/re) is accepted on any rising edge where busy is low and
  // is silently dropped while busy is high; dout_vld is a single-cycle strobe, there is
  // no backpressure on the read data.
  logic              clr;
  logic              busy;
  logic              we;
  logic              re;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  logic              dout_vld;
  ram_state_t        state;

  modport master (
    output clr, we, re, addr, din,
    input  busy, dout, dout_vld, state
  );

  modport slave (
    input  clr, we, re, addr, din,
    output busy, dout, dout_vld, state
  );

endinterface

// File: rtl/ram_sp_core.sv
// Inferred single-port array: synchronous write, registered read with selectable
// read-during-write behaviour.
module ram_sp_core
  import ram_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 8,
  parameter bit WRITE_FIRST = RAM_READ_FIRST
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // The array itself carries no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      if ((WRITE_FIRST == RAM_WRITE_FIRST) && we) begin
        rdata <= din;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/ram_sp_clr.sv
// Single-port RAM with a clear sweep after reset or on clr request.
// Optional feature macro: RAM_OUT_REG_EN adds an output register (read latency 2).
module ram_sp_clr
  import ram_pkg::*;
#(
  parameter int              DATA_W      = 16,
  parameter int              ADDR_W      = 8,
  parameter logic [DATA_W-1:0] INIT_VAL  = '0,
  parameter bit              WRITE_FIRST = RAM_READ_FIRST
) (
  input logic         clk,
  input logic         rst,
  ram_sp_clr_if.slave bus
);

  ram_state_t        state;
  logic [ADDR_W-1:0] cnt;
  logic              clearing;
  logic              core_we;
  logic              core_re;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_din;
  logic [DATA_W-1:0] rdata;
  logic              rd_vld;

  assign clearing = (state == CLEAR);

  // clr wins over the end of a sweep so a late request always restarts at 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      cnt   <= '0;
    end else if (bus.clr) begin
      state <= CLEAR;
      cnt   <= '0;
    end else if (clearing) begin
      cnt <= cnt + ADDR_W'(1);
      if (sweep_last(32'(cnt), ADDR_W)) begin
        state <= IDLE;
      end
    end
  end

  always_comb begin
    core_we   = bus.we;
    core_re   = bus.re;
    core_addr = bus.addr;
    core_din  = bus.din;
    if (clearing) begin
      core_we   = 1'b1;
      core_re   = 1'b0;
      core_addr = cnt;
      core_din  = INIT_VAL;
    end
  end

  ram_sp_core #(
    .DATA_W      (DATA_W),
    .ADDR_W      (ADDR_W),
    .WRITE_FIRST (WRITE_FIRST)
  ) u_core (
    .clk   (clk),
    .rst   (rst),
    .we    (core_we),
    .re    (core_re),
    .addr  (core_addr),
    .din   (core_din),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld <= 1'b0;
    end else begin
      rd_vld <= core_re;
    end
  end

`ifdef RAM_OUT_REG_EN
  logic [DATA_W-1:0] dout_q;
  logic              vld_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      vld_q <= rd_vld;
      if (rd_vld) begin
        dout_q <= rdata;
      end
    end
  end

  assign bus.dout     = dout_q;
  assign bus.dout_vld = vld_q;
`else
  assign bus.dout     = rdata;
  assign bus.dout_vld = rd_vld;
`endif

  assign bus.busy  = clearing;
  assign bus.state = state;

endmodule

// File: tb/tb_ram_sp_clr.sv
// Bench for ram_sp_clr: read-first and write-first instances driven in lockstep.
module tb_ram_sp_clr;
  import ram_pkg::*;

  localparam int DW = 16;
  localparam int AW = 8;
  localparam logic [DW-1:0] INIT = 16'hFF00;
`ifdef RAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    logic          we;
    logic          re;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic [DW-1:0] e0;
    logic [DW-1:0] e1;
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ram_sp_clr_if #(.DATA_W(DW), .ADDR_W(AW)) b0 ();
  ram_sp_clr_if #(.DATA_W(DW), .ADDR_W(AW)) b1 ();

  ram_sp_clr #(.DATA_W(DW), .ADDR_W(AW), .INIT_VAL(INIT), .WRITE_FIRST(RAM_READ_FIRST))
    dut0 (.clk(clk), .rst(rst), .bus(b0));
  ram_sp_clr #(.DATA_W(DW), .ADDR_W(AW), .INIT_VAL(INIT), .WRITE_FIRST(RAM_WRITE_FIRST))
    dut1 (.clk(clk), .rst(rst), .bus(b1));

  // scoreboard
  logic [DW-1:0] exp_q0[$];
  logic [DW-1:0] exp_q1[$];
  int            due_q0[$];
  int            due_q1[$];
  int            n_cmp = 0;
  int            n_err = 0;
  logic [DW-1:0] mem_m [256];
  logic [DW-1:0] last_e0, last_e1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (b0.dout_vld) begin
      if (exp_q0.size() == 0) check("spurious_vld0", 32'(b0.dout_vld), 32'd0);
      else begin
        check("dout0", 32'(b0.dout), 32'(exp_q0.pop_front()));
        check("lat0", cyc, due_q0.pop_front());
      end
    end else if (due_q0.size() > 0 && due_q0[0] <= cyc) begin
      check("missing_vld0", 32'(b0.dout_vld), 32'd1);
      void'(exp_q0.pop_front());
      void'(due_q0.pop_front());
    end
    if (b1.dout_vld) begin
      if (exp_q1.size() == 0) check("spurious_vld1", 32'(b1.dout_vld), 32'd0);
      else begin
        check("dout1", 32'(b1.dout), 32'(exp_q1.pop_front()));
        check("lat1", cyc, due_q1.pop_front());
      end
    end else if (due_q1.size() > 0 && due_q1[0] <= cyc) begin
      check("missing_vld1", 32'(b1.dout_vld), 32'd1);
      void'(exp_q1.pop_front());
      void'(due_q1.pop_front());
    end
  end

  // driver tasks
  task automatic drive(input logic c, input logic w, input logic r,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    b0.clr = c; b0.we = w; b0.re = r; b0.addr = a; b0.din = d;
    b1.clr = c; b1.we = w; b1.re = r; b1.addr = a; b1.din = d;
  endtask

  task automatic step(input vec_t v);
    drive(1'b0, v.we, v.re, v.addr, v.din);
    if (v.re) begin
      exp_q0.push_back(v.e0); due_q0.push_back(cyc + LAT);
      exp_q1.push_back(v.e1); due_q1.push_back(cyc + LAT);
      last_e0 = v.e0;
      last_e1 = v.e1;
    end
    if (v.we) mem_m[v.addr] = v.din;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic w, input logic r, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, input logic [DW-1:0] e0,
                              input logic [DW-1:0] e1);
    vec_t v;
    v.we = w; v.re = r; v.addr = a; v.din = d; v.e0 = e0; v.e1 = e1;
    return v;
  endfunction

  task automatic read(input logic [AW-1:0] a);
    step(mk(1'b0, 1'b1, a, '0, mem_m[a], mem_m[a]));
  endtask

  task automatic drain(input string name);
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    repeat (LAT + 2) @(posedge clk);
    #1;
    check({name, "_pending"}, 32'(exp_q0.size() + exp_q1.size()), 32'd0);
  endtask

  // Counts negedges with busy high until it falls; bounded. Optionally pokes a
  // write+read to 0x05 with BEEF in the 10th busy cycle.
  task automatic count_busy(input string name, input bit poke);
    int n;
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (!b0.busy) break;
      n++;
      if (poke && n == 10) drive(1'b0, 1'b1, 1'b1, 8'h05, 16'hBEEF);
      if (poke && n == 11) drive(1'b0, 1'b0, 1'b0, '0, '0);
    end
    check(name, n, 256);
    check({name, "_b1"}, 32'(b1.busy), 32'd0);
    check({name, "_state"}, 32'(b0.state), 32'(IDLE));
    for (int a = 0; a < 256; a++) mem_m[a] = INIT;
  endtask

  vec_t vt[16];

  initial begin
    vt[0]  = mk(0, 1, 8'h00, 16'h0000, INIT, INIT);
    vt[1]  = mk(0, 1, 8'h7F, 16'h0000, INIT, INIT);
    vt[2]  = mk(0, 1, 8'hFF, 16'h0000, INIT, INIT);
    vt[3]  = mk(1, 0, 8'h10, 16'h1234, 16'h0000, 16'h0000);
    vt[4]  = mk(0, 1, 8'h10, 16'h0000, 16'h1234, 16'h1234);
    vt[5]  = mk(1, 0, 8'h20, 16'hAAAA, 16'h0000, 16'h0000);
    vt[6]  = mk(1, 1, 8'h20, 16'h5555, 16'hAAAA, 16'h5555);
    vt[7]  = mk(0, 1, 8'h20, 16'h0000, 16'h5555, 16'h5555);
    vt[8]  = mk(0, 1, 8'h10, 16'h0000, 16'h1234, 16'h1234);
    vt[9]  = mk(0, 0, 8'h33, 16'h0000, 16'h0000, 16'h0000);
    vt[10] = mk(0, 1, 8'h33, 16'h0000, INIT, INIT);
    vt[11] = mk(1, 0, 8'hFF, 16'h0001, 16'h0000, 16'h0000);
    vt[12] = mk(0, 1, 8'hFF, 16'h0000, 16'h0001, 16'h0001);
    vt[13] = mk(1, 1, 8'h00, 16'hFFFF, INIT, 16'hFFFF);
    vt[14] = mk(0, 1, 8'h00, 16'h0000, 16'hFFFF, 16'hFFFF);
    vt[15] = mk(0, 1, 8'hFF, 16'h0000, 16'h0001, 16'h0001);

    // reset state
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(b0.busy), 32'd1);
    check("rst_dout", 32'(b0.dout), 32'd0);
    check("rst_vld", 32'(b0.dout_vld), 32'd0);
    check("rst_state", 32'(b0.state), 32'(CLEAR));
    rst = 1'b0;
    count_busy("busy_after_rst", 1'b0);

    for (int i = 0; i < 16; i++) step(vt[i]);
    drain("table");

    // random traffic against the model
    for (int i = 0; i < 60; i++) begin
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      int            op;
      a  = AW'($urandom_range(0, 255));
      d  = DW'($urandom_range(0, 65535));
      op = $urandom_range(0, 2);
      if (op == 0) step(mk(1, 0, a, d, '0, '0));
      else if (op == 1) read(a);
      else step(mk(1, 1, a, d, mem_m[a], d));
    end
    drain("random");
    step(mk(1, 0, 8'h64, 16'h00C3, '0, '0));
    read(8'h64);
    drain("pre_clr");

    // clr from IDLE, restart at counter 100, write attempt while busy
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    check("clr_busy_rise", 32'(b0.busy), 32'd1);
    repeat (100) @(posedge clk);
    #1;
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    count_busy("busy_after_restart", 1'b1);
    check("dout_hold0", 32'(b0.dout), 32'(last_e0));
    check("dout_hold1", 32'(b1.dout), 32'(last_e1));
    read(8'h05);
    read(8'h10);
    read(8'h64);
    read(8'h7F);
    drain("post_clr");

    // reset during an IDLE read
    drive(1'b0, 1'b0, 1'b1, 8'h05, '0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    check("rrd_dout", 32'(b0.dout), 32'd0);
    check("rrd_vld", 32'(b0.dout_vld), 32'd0);
    check("rrd_busy", 32'(b0.busy), 32'd1);
    check("rrd_dout1", 32'(b1.dout), 32'd0);
    count_busy("busy_after_rst2", 1'b0);
    read(8'h20);
    read(8'hFF);
    drain("final");

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ram_sp_clr.md
# ram_sp_clr

Parametrised single-port synchronous RAM for the memory/display datapath, where the address sequencer drives `addr` and switch inputs drive `din`. It is the next generation of the fixed 256 x 16 store. It adds configurable width and depth, an explicit read enable with a valid strobe, and a selectable read-during-write mode. It also adds a hardware clear engine that sweeps every location to a constant after reset or on request, so the display never shows uninitialised contents.

## Interface
- `DATA_W`, default 16: word width in bits.
- `ADDR_W`, default 8: address width; depth = 2**ADDR_W.
- `INIT_VAL`, default 16'h0000: value written to every location by the clear engine; DATA_W bits.
- `WRITE_FIRST`, default 0: read-during-write mode. 0 = read-first (old data); 1 = write-first (new data).
- `clk`, input, 1: sole clock; all logic on its rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `clr`, input, 1: single-cycle request to start a clear sweep.
- `busy`, output, 1: high while the clear sweep runs; user accesses are ignored.
- `we`, input, 1: write enable.
- `re`, input, 1: read enable.
- `addr`, input, ADDR_W: user address.
- `din`, input, DATA_W: write data.
- `dout`, output, DATA_W: read data.
- `dout_vld`, output, 1: one-cycle strobe marking a new `dout`.

## Operation
- States: CLEAR and IDLE.
- Reset values:
  - state = CLEAR, clear counter = 0.
  - `busy` = 1, `dout` = 0, `dout_vld` = 0.
  - Any output pipeline register = 0.
- CLEAR:
  - Each cycle writes `INIT_VAL` to mem[counter], then increments the counter.
  - At counter = 2**ADDR_W-1, performs the final write and moves to IDLE.
  - The counter wraps to 0 on exit.
  - `we`, `re` and `addr` are ignored.
  - `dout` holds its value and `dout_vld` = 0.
- IDLE:
  - `busy` = 0.
  - `we`=1 writes `din` to mem[`addr`].
  - `re`=1 launches a read of mem[`addr`].
- `we`=1 and `re`=1 in the same cycle (same address by construction):
  - `WRITE_FIRST`=0: `dout` returns the prior contents.
  - `WRITE_FIRST`=1: `dout` returns `din`.
- `re`=0: `dout` holds its last value and `dout_vld` = 0.
- `clr`:
  - In IDLE: enter CLEAR next cycle with counter = 0.
  - In CLEAR: restart the sweep at counter 0.
  - Same cycle as a user `we`/`re`: the user access is performed first, then CLEAR is entered.
- `rst` mid-sweep or mid-read: returns to the reset state immediately. Contents already written are not guaranteed; the new sweep overwrites everything.
- Address arithmetic is ADDR_W-bit unsigned. No out-of-range addresses exist.

## Timing
- Read latency is 1 cycle: `re` sampled at edge N gives `dout` and `dout_vld`=1 after edge N.
- Write takes effect at the sampling edge. A read of the same address issued on the next cycle returns the new data.
- Clear sweep: `busy` is high for exactly 2**ADDR_W cycles after `rst` deasserts (256 cycles at defaults). `busy` falls the cycle after the last clear write.
- After an IDLE `clr`, `busy` rises on the next edge and stays high for 2**ADDR_W cycles.
- Back-to-back reads are supported: one result per cycle, full throughput.

## Configuration
- `RAM_OUT_REG_EN` defined:
  - Adds an output register stage after the memory read.
  - Read latency becomes 2 cycles; `dout_vld` is delayed to match.
  - The register resets to 0.
  - Improves clock-to-out timing for the mux/decoder path.
- `RAM_OUT_REG_EN` undefined: latency is 1 cycle as in Timing.
- Sweep length, `busy` timing and read-during-write semantics are unchanged in both builds.

## Structure
- Shared package `ram_pkg`:
  - state enum `ram_state_t` {CLEAR, IDLE}.
  - mode constants `RAM_READ_FIRST`=0 and `RAM_WRITE_FIRST`=1.
- Sub-module `ram_sp_core`: a plain inferred array with a synchronous write port and a registered read port, parametrised by DATA_W, ADDR_W and WRITE_FIRST.
- Top level `ram_sp_clr` holds:
  - the CLEAR/IDLE FSM and clear counter;
  - the muxing of counter/`INIT_VAL` versus `addr`/`din` into the core;
  - valid generation and the optional output register.

## Test plan
- Reset release with INIT_VAL=16'hFF00: `busy`=1 for exactly 256 cycles. Then reads of addresses 0x00, 0x7F and 0xFF each return 16'hFF00 with `dout_vld` pulsing once per read.
- Write 16'h1234 to 0x10, then read 0x10: `dout`=16'h1234 one cycle later (two cycles with `RAM_OUT_REG_EN`).
- Address 0x20 holds 16'hAAAA; drive `we`=`re`=1 with `din`=16'h5555:
  - WRITE_FIRST=0: `dout`=16'hAAAA.
  - WRITE_FIRST=1: `dout`=16'h5555.
  - A following read returns 16'h5555 in both modes.
- `we`=1 with `din`=16'hBEEF at 0x05 while `busy`=1: no write occurs and `dout_vld` stays 0. After the sweep, 0x05 reads INIT_VAL.
- Pulse `clr` at counter 100 of a sweep: the sweep restarts at 0 and `busy` stays high 256 more cycles.
- Assert `rst` during an IDLE read: next cycle `dout`=0, `dout_vld`=0, `busy`=1, and a full sweep follows.
